// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the gshare predictor (2-bit counter, BTB entry, counter step)
package bp_pkg;
  localparam int BP_XLEN = 32;
  localparam int BP_TAG_W = 8;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  typedef struct packed {
    logic valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0] target;
  } btb_entry_t;
  localparam ctr_t CTR_RESET = WNT;
  function automatic ctr_t ctr_step(ctr_t c, logic up);
    return up ? (c == ST ? ST : ctr_t'(c + 2'd1)) : (c == SNT ? SNT : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/bp_btb.sv
// bp_btb: direct-mapped tagged BTB with WAYS read ports, WAYS ordered write ports and sync clear
module bp_btb
  import bp_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SIZE = 64,
  parameter int XLEN = BP_XLEN,
  parameter int TAG_W = BP_TAG_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WAYS-1:0][XLEN-1:0]  rd_pc,
  output logic [WAYS-1:0]            rd_hit,
  output logic [WAYS-1:0][XLEN-1:0]  rd_target,
  input  logic [WAYS-1:0]            wr_en,
  input  logic [WAYS-1:0][XLEN-1:0]  wr_pc,
  input  logic [WAYS-1:0][XLEN-1:0]  wr_target
);
  localparam int IW = $clog2(SIZE);
  btb_entry_t mem [SIZE];
  logic unused;
  assign unused = ^{rd_pc, wr_pc};
  always_comb
    for (int i = 0; i < WAYS; i++) begin
      rd_hit[i] = mem[rd_pc[i][IW+1:2]].valid && mem[rd_pc[i][IW+1:2]].tag == rd_pc[i][IW+2+:TAG_W];
      rd_target[i] = mem[rd_pc[i][IW+1:2]].target;
    end
  // ascending loop: a later port writing the same entry wins
  always_ff @(posedge clock)
    if (reset)
      for (int k = 0; k < SIZE; k++) mem[k] <= '0;
    else
      for (int i = 0; i < WAYS; i++)
        if (wr_en[i]) mem[wr_pc[i][IW+1:2]] <= '{1'b1, wr_pc[i][IW+2+:TAG_W], wr_target[i]};
endmodule

// File: rtl/bp_gshare.sv
// bp_gshare: BTB + 2-bit PHT fetch predictor; define BP_GSHARE_EN for GHR-XOR indexing and
// speculative history with recovery (otherwise PC-only indexing and GHR held at 0)
module bp_gshare
  import bp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int WAYS = 2,
  parameter int PHT_SIZE = 256,
  parameter int BTB_SIZE = 64,
  parameter int TAG_W = 8,
  parameter int GHR_W = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [XLEN-1:0]             fetch_PC,
  input  logic                        fetch_valid,
  output logic [XLEN-1:0]             next_PC,
  output logic [WAYS-1:0]             predictions,
  output logic [GHR_W-1:0]            pred_ghr,
  input  logic [WAYS-1:0]             valid_update,
  input  logic [WAYS-1:0][XLEN-1:0]   PC_update,
  input  logic [WAYS-1:0]             direction_update,
  input  logic [WAYS-1:0][XLEN-1:0]   target_update,
  input  logic [WAYS-1:0][GHR_W-1:0]  ghr_update,
  input  logic                        recover,
  input  logic [GHR_W-1:0]            recover_ghr,
  input  logic                        recover_taken
);
  localparam int PIW = $clog2(PHT_SIZE);
  ctr_t pht [PHT_SIZE];
  ctr_t u_val [WAYS];
  logic [GHR_W-1:0] ghr;
  logic [WAYS-1:0][XLEN-1:0] slot_pc, btb_target;
  logic [WAYS-1:0][PIW-1:0] f_idx, u_idx;
  logic [WAYS-1:0] hit, taken;
  logic shift_en, found, unused;
  bp_btb #(.WAYS(WAYS), .SIZE(BTB_SIZE), .XLEN(XLEN), .TAG_W(TAG_W)) u_btb (
    .clock(clock),
    .reset(reset),
    .rd_pc(slot_pc),
    .rd_hit(hit),
    .rd_target(btb_target),
    .wr_en(valid_update & direction_update),
    .wr_pc(PC_update),
    .wr_target(target_update)
  );
  always_comb
    for (int i = 0; i < WAYS; i++) begin
      slot_pc[i] = fetch_PC + XLEN'(4 * i);
`ifdef BP_GSHARE_EN
      f_idx[i] = slot_pc[i][PIW+1:2] ^ PIW'(ghr);
      u_idx[i] = PC_update[i][PIW+1:2] ^ PIW'(ghr_update[i]);
`else
      f_idx[i] = slot_pc[i][PIW+1:2];
      u_idx[i] = PC_update[i][PIW+1:2];
`endif
      taken[i] = hit[i] && pht[f_idx[i]] >= WT;
    end
  // lowest taken slot wins; history only advances if a BTB hit precedes or is the winner
  always_comb begin
    next_PC = fetch_PC + XLEN'(4 * WAYS);
    predictions = '0;
    shift_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < WAYS; i++)
      if (!found) begin
        shift_en = shift_en | hit[i];
        found = taken[i];
        predictions[i] = taken[i];
        next_PC = taken[i] ? btb_target[i] : next_PC;
      end
  end
  // each port's counter value folds in every earlier port that targets the same entry
  always_comb
    for (int i = 0; i < WAYS; i++) begin
      u_val[i] = pht[u_idx[i]];
      for (int j = 0; j <= i; j++)
        u_val[i] = (valid_update[j] && u_idx[j] == u_idx[i]) ? ctr_step(u_val[i], direction_update[j]) : u_val[i];
    end
  always_ff @(posedge clock)
    if (reset)
      for (int k = 0; k < PHT_SIZE; k++) pht[k] <= CTR_RESET;
    else
      for (int i = 0; i < WAYS; i++)
        if (valid_update[i]) pht[u_idx[i]] <= u_val[i];
`ifdef BP_GSHARE_EN
  always_ff @(posedge clock)
    if (reset) ghr <= '0;
    else if (recover) ghr <= {recover_ghr[GHR_W-2:0], recover_taken};
    else if (fetch_valid && shift_en) ghr <= {ghr[GHR_W-2:0], |predictions};
  assign unused = recover_ghr[GHR_W-1];
`else
  assign ghr = '0;
  assign unused = ^{ghr_update, recover, recover_ghr, recover_taken, fetch_valid, shift_en};
`endif
  assign pred_ghr = ghr;
endmodule

// File: tb/tb_bp_gshare.sv
// tb_bp_gshare: directed scenarios plus randomized traffic checked against a table-level model
module tb_bp_gshare;
  localparam int WAYS = 2, PHT_SIZE = 256, BTB_SIZE = 64, TAG_W = 8;
`ifdef BP_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset;
  logic [31:0] fetch_PC;
  logic fetch_valid;
  logic [31:0] next_PC;
  logic [1:0] predictions;
  logic [7:0] pred_ghr;
  logic [1:0] valid_update;
  logic [1:0][31:0] PC_update;
  logic [1:0] direction_update;
  logic [1:0][31:0] target_update;
  logic [1:0][7:0] ghr_update;
  logic recover;
  logic [7:0] recover_ghr;
  logic recover_taken;
  int checks = 0;
  int failures = 0;
  int m_ctr [PHT_SIZE];
  bit m_v [BTB_SIZE];
  int unsigned m_tag [BTB_SIZE];
  logic [31:0] m_tgt [BTB_SIZE];
  int unsigned m_ghr;
  logic [31:0] e_npc;
  logic [1:0] e_pred;
  bit e_hit;

  bp_gshare dut (
    .clock(clock), .reset(reset), .fetch_PC(fetch_PC), .fetch_valid(fetch_valid),
    .next_PC(next_PC), .predictions(predictions), .pred_ghr(pred_ghr),
    .valid_update(valid_update), .PC_update(PC_update), .direction_update(direction_update),
    .target_update(target_update), .ghr_update(ghr_update), .recover(recover),
    .recover_ghr(recover_ghr), .recover_taken(recover_taken)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int k = 0; k < PHT_SIZE; k++) m_ctr[k] = 1;
    for (int k = 0; k < BTB_SIZE; k++) m_v[k] = 1'b0;
    m_ghr = 0;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output logic [31:0] npc,
                                     output logic [1:0] pred, output bit hit_seen);
    npc = pc + 32'd8;
    pred = 2'b00;
    hit_seen = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      logic [31:0] p;
      int unsigned b, pi;
      bit h;
      p = pc + 32'(4 * i);
      b = int'(p >> 2) % BTB_SIZE;
      pi = (int'(p >> 2) ^ (GS ? m_ghr : 0)) % PHT_SIZE;
      h = m_v[b] && m_tag[b] == int'(p >> 8) % (1 << TAG_W);
      hit_seen |= h;
      if (h && m_ctr[pi] >= 2) begin
        pred[i] = 1'b1;
        npc = m_tgt[b];
        return;
      end
    end
  endfunction

  function automatic void model_edge();
    logic [31:0] npc;
    logic [1:0] pred;
    bit hs;
    model_pred(fetch_PC, npc, pred, hs);
    if (reset) begin
      model_reset();
      return;
    end
    for (int j = 0; j < WAYS; j++)
      if (valid_update[j]) begin
        int unsigned pi, b;
        pi = (int'(PC_update[j] >> 2) ^ (GS ? int'(ghr_update[j]) : 0)) % PHT_SIZE;
        m_ctr[pi] = direction_update[j] ? (m_ctr[pi] == 3 ? 3 : m_ctr[pi] + 1)
                                        : (m_ctr[pi] == 0 ? 0 : m_ctr[pi] - 1);
        if (direction_update[j]) begin
          b = int'(PC_update[j] >> 2) % BTB_SIZE;
          m_v[b] = 1'b1;
          m_tag[b] = int'(PC_update[j] >> 8) % (1 << TAG_W);
          m_tgt[b] = target_update[j];
        end
      end
    if (GS && recover) m_ghr = (int'(recover_ghr) * 2 + int'(recover_taken)) % 256;
    else if (GS && fetch_valid && hs) m_ghr = (m_ghr * 2 + (pred != 0 ? 1 : 0)) % 256;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    fetch_PC = 32'h0;
    fetch_valid = 1'b0;
    valid_update = 2'b00;
    PC_update = '0;
    direction_update = 2'b00;
    target_update = '0;
    ghr_update = '0;
    recover = 1'b0;
    recover_ghr = 8'h00;
    recover_taken = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    fetch_PC = 32'h100;
    #2;
    checks++;
    if (next_PC !== 32'h108 || predictions !== 2'b00 || pred_ghr !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got npc=%h pred=%b ghr=%h want 00000108 00 00", next_PC, predictions, pred_ghr);
    end
    fetch_PC = 32'hFFFF_FFFC;
    #2;
    checks++;
    if (next_PC !== 32'h0000_0004 || predictions !== 2'b00) begin
      failures++;
      $display("FAIL fallthrough_wrap: got npc=%h pred=%b want 00000004 00", next_PC, predictions);
    end
  endtask

  task automatic test_train_single();
    valid_update = 2'b01;
    direction_update = 2'b01;
    PC_update[0] = 32'h104;
    target_update[0] = 32'h400;
    ghr_update[0] = 8'h00;
    fetch_PC = 32'h100;
    #2;
    checks++;
    if (predictions !== 2'b00 || next_PC !== 32'h108) begin
      failures++;
      $display("FAIL no_bypass: got npc=%h pred=%b want 00000108 00", next_PC, predictions);
    end
    tick();
    valid_update = 2'b00;
    #2;
    checks++;
    if (predictions !== 2'b10 || next_PC !== 32'h400) begin
      failures++;
      $display("FAIL train_single: got npc=%h pred=%b want 00000400 10", next_PC, predictions);
    end
  endtask

  task automatic test_alias();
    fetch_PC = 32'h104 + 32'(4 * BTB_SIZE);
    #2;
    checks++;
    if (predictions !== 2'b00 || next_PC !== 32'h20C) begin
      failures++;
      $display("FAIL alias_tag: got npc=%h pred=%b want 0000020c 00", next_PC, predictions);
    end
    fetch_PC = 32'h104;
    #2;
    checks++;
    if (predictions !== 2'b01 || next_PC !== 32'h400) begin
      failures++;
      $display("FAIL slot0_hit: got npc=%h pred=%b want 00000400 01", next_PC, predictions);
    end
  endtask

  task automatic test_dual_update();
    valid_update = 2'b11;
    direction_update = 2'b11;
    PC_update = {32'h310, 32'h310};
    target_update = {32'h500, 32'h500};
    ghr_update = '0;
    tick();
    valid_update = 2'b00;
    fetch_PC = 32'h310;
    #2;
    checks++;
    if (predictions !== 2'b01 || next_PC !== 32'h500) begin
      failures++;
      $display("FAIL dual_taken: got npc=%h pred=%b want 00000500 01", next_PC, predictions);
    end
    valid_update = 2'b01;
    direction_update = 2'b00;
    tick();
    valid_update = 2'b00;
    #2;
    checks++;
    if (predictions !== 2'b01 || next_PC !== 32'h500) begin
      failures++;
      $display("FAIL saturate_11: got npc=%h pred=%b want 00000500 01", next_PC, predictions);
    end
    valid_update = 2'b11;
    tick();
    valid_update = 2'b00;
    #2;
    checks++;
    if (predictions !== 2'b00 || next_PC !== 32'h318) begin
      failures++;
      $display("FAIL dual_not_taken: got npc=%h pred=%b want 00000318 00", next_PC, predictions);
    end
  endtask

  task automatic test_ghr();
    fetch_valid = 1'b1;
    fetch_PC = 32'h100;
    #2;
    checks++;
    if (predictions !== 2'b10 || pred_ghr !== 8'h00) begin
      failures++;
      $display("FAIL ghr_first: got pred=%b ghr=%h want 10 00", predictions, pred_ghr);
    end
    tick();
    fetch_PC = 32'h310;
    #2;
    checks++;
    if (pred_ghr !== (GS ? 8'h01 : 8'h00) || predictions !== 2'b00 || next_PC !== 32'h318) begin
      failures++;
      $display("FAIL ghr_taken_shift: got ghr=%h pred=%b npc=%h want %h 00 00000318", pred_ghr, predictions, next_PC, GS ? 8'h01 : 8'h00);
    end
    tick();
    checks++;
    if (pred_ghr !== (GS ? 8'h02 : 8'h00)) begin
      failures++;
      $display("FAIL ghr_nt_shift: got ghr=%h want %h", pred_ghr, GS ? 8'h02 : 8'h00);
    end
    fetch_PC = 32'h100;
    recover = 1'b1;
    recover_ghr = 8'h55;
    recover_taken = 1'b1;
    tick();
    recover = 1'b0;
    fetch_valid = 1'b0;
    #2;
    checks++;
    if (pred_ghr !== (GS ? 8'hAB : 8'h00)) begin
      failures++;
      $display("FAIL ghr_recover: got ghr=%h want %h", pred_ghr, GS ? 8'hAB : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    fetch_valid = 1'b1;
    fetch_PC = 32'h100;
    valid_update = 2'b11;
    direction_update = 2'b11;
    PC_update = {32'h104, 32'h104};
    target_update = {32'h800, 32'h800};
    ghr_update = '0;
    tick();
    reset = 1'b0;
    valid_update = 2'b00;
    fetch_valid = 1'b0;
    #2;
    checks++;
    if (next_PC !== 32'h108 || predictions !== 2'b00 || pred_ghr !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: got npc=%h pred=%b ghr=%h want 00000108 00 00", next_PC, predictions, pred_ghr);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h1000 + 32'($urandom_range(0, 1) << 8) + 32'($urandom_range(0, 15) << 2);
  endfunction

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      fetch_PC = rand_pc();
      fetch_valid = 1'($urandom_range(0, 1));
      for (int j = 0; j < WAYS; j++) begin
        valid_update[j] = 1'($urandom_range(0, 1));
        direction_update[j] = ($urandom_range(0, 2) != 0);
        PC_update[j] = rand_pc();
        target_update[j] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        ghr_update[j] = $urandom_range(0, 1) ? 8'(m_ghr) : 8'($urandom);
      end
      recover = ($urandom_range(0, 19) == 0);
      recover_ghr = 8'($urandom);
      recover_taken = 1'($urandom_range(0, 1));
      #2;
      model_pred(fetch_PC, e_npc, e_pred, e_hit);
      checks++;
      if (next_PC !== e_npc || predictions !== e_pred || pred_ghr !== 8'(m_ghr)) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL random[%0d]: pc=%h got npc=%h pred=%b ghr=%h want %h %b %h",
                   n, fetch_PC, next_PC, predictions, pred_ghr, e_npc, e_pred, 8'(m_ghr));
      end
      tick();
    end
    clear_inputs();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_train_single();
    test_alias();
    test_dual_update();
    test_ghr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
